// File: rtl/divider_radix2_unit_pkg.sv
// rtl/divider_radix2_unit_pkg.sv - shared types for the radix-2 divider
package common;

  typedef logic [63:0]  u64;
  typedef logic [127:0] u128;

  // Divider control states
  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  // One quotient bit per BUSY cycle for a 64-bit operand
  localparam int DIV_ITERS = 64;

endpackage

// File: rtl/divider_radix2_unit_div_step.sv
// rtl/divider_radix2_unit_div_step.sv - one restoring shift-subtract iteration
module div_step
  import common::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The partial remainder is WIDTH+1 bits: rem's MSB is the carry-out of the
  // shift and must take part in the compare, otherwise divisors above
  // 2^(WIDTH-1) fail.
  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;
  logic           ge;

  // Shift in the next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    t    = {rem, quo[WIDTH-1]};
    diff = t - {1'b0, dvs};
    // rem < dvs holds on entry, so a successful subtract never sets diff's
    // top bit; a borrow always does.
    ge       = ~diff[WIDTH];
    rem_next = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/divider_radix2_unit.sv
// rtl/divider_radix2_unit.sv - multicycle unsigned restoring divider, {rem, quo} result
module divider_radix2_unit
  import common::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State and datapath registers; reset clears everything so c reads zero at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  // Next-state and datapath load/iterate decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;

    case (state_q)
      DIV_IDLE: begin
        if (valid) begin
          if (b != '0) begin
            rem_d   = '0;
            quo_d   = a;
            dvs_d   = b;
            cnt_d   = '0;
            state_d = DIV_BUSY;
          end else begin
            // Divide by zero: all-ones quotient, dividend as remainder
            quo_d   = '1;
            rem_d   = a;
            state_d = DIV_DONE;
          end
        end
      end

      DIV_BUSY: begin
        if (!valid) begin
          // Requester flushed or bubbled; drop the operation silently
          state_d = DIV_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  assign done = (state_q == DIV_DONE);
  assign c    = {rem_q, quo_q};

endmodule

// File: tb/tb_divider_radix2_unit.sv
// tb/tb_divider_radix2_unit.sv - scoreboard bench for divider_radix2_unit
module tb_divider_radix2_unit;
  import common::*;

  localparam int W = 64;

  typedef struct {
    u64 q;
    u64 r;
    int cyc;
    string name;
  } exp_t;

  logic   clk;
  logic   reset;
  logic   valid;
  u64     a;
  u64     b;
  logic   done;
  u128    c;

  int     checks;
  int     errors;
  int     cyc;
  logic   prev_done;
  exp_t   sb[$];

  divider_radix2_unit #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .a     (a),
    .b     (b),
    .done  (done),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: a request presented at a negedge is accepted at edge cyc+1
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per done pulse and checks result and timing
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        exp_t e;
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_pulse_width: done high on two consecutive cycles at edge %0d", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got c=%h at edge %0d, required no done", c, cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (c[W-1:0] !== e.q) begin
            errors++;
            $display("FAIL %s quotient: got %h required %h", e.name, c[W-1:0], e.q);
          end
          checks++;
          if (c[2*W-1:W] !== e.r) begin
            errors++;
            $display("FAIL %s remainder: got %h required %h", e.name, c[2*W-1:W], e.r);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s latency: done at edge %0d required edge %0d", e.name, cyc, e.cyc);
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done=0 after 200 cycles, required done=1", name);
    end
  endtask

  // Issue from IDLE, wait for done, release valid on the done cycle
  task automatic req(input u64 av, input u64 bv, input u64 q, input u64 r, input string name);
    exp_t e;
    @(negedge clk);
    valid = 1'b1;
    a     = av;
    b     = bv;
    e.q    = q;
    e.r    = r;
    e.cyc  = cyc + 1 + ((bv == 0) ? 0 : W);
    e.name = name;
    sb.push_back(e);
    wait_done(name);
    valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    cyc    = 0;
    prev_done = 1'b0;
    reset  = 1'b1;
    valid  = 1'b0;
    a      = '0;
    b      = '0;

    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b required 0", done);
    end
    checks++;
    if (c !== '0) begin
      errors++;
      $display("FAIL reset_c: got %h required 0", c);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    req(64'd100, 64'd7, 64'd14, 64'd2, "div_100_7");
    req(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
        64'd1, 64'h7FFF_FFFF_FFFF_FFFE, "div_wide_rem");
    req(64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12345, "div_by_zero");
    req(64'd0, 64'd5, 64'd0, 64'd0, "div_zero_dividend");
    req(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "div_max_2");
    req(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "div_max_max");
    req(64'hDEAD_BEEF, 64'h10, 64'h0DEA_DBEE, 64'hF, "div_hex_16");
    req(64'd5, 64'd9, 64'd0, 64'd5, "div_small_large");

    // Abort mid-BUSY: no done may appear
    @(negedge clk);
    valid = 1'b1;
    a     = 64'd1000;
    b     = 64'd3;
    repeat (20) @(negedge clk);
    valid = 1'b0;
    repeat (80) @(negedge clk);
    req(64'd9, 64'd4, 64'd2, 64'd1, "after_abort");

    // Back-to-back with valid held; second operands presented on done
    @(negedge clk);
    valid = 1'b1;
    a     = 64'd50;
    b     = 64'd5;
    e.q = 64'd10; e.r = 64'd0; e.cyc = cyc + 1 + W; e.name = "b2b_first";
    sb.push_back(e);
    wait_done("b2b_first");
    a = 64'd7;
    b = 64'd9;
    e.q = 64'd0; e.r = 64'd7; e.cyc = cyc + 2 + W; e.name = "b2b_second";
    sb.push_back(e);
    wait_done("b2b_second");
    valid = 1'b0;

    // Asynchronous reset between edges in the middle of BUSY
    @(negedge clk);
    valid = 1'b1;
    a     = 64'd100;
    b     = 64'd7;
    repeat (30) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_done: got %b required 0", done);
    end
    checks++;
    if (c !== '0) begin
      errors++;
      $display("FAIL async_reset_c: got %h required 0", c);
    end
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (c !== '0) begin
      errors++;
      $display("FAIL idle_after_reset_c: got %h required 0", c);
    end
    req(64'd100, 64'd7, 64'd14, 64'd2, "after_reset");

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
